vga_sincronismo: RTL and testbench



---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_divisor_pixel.sv | 29 ++
 rtl/vga_sincronismo.sv | 112 +++++++++++
 tb/tb_vga_sincronismo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals and grid mapping constants.
// Imported by the sync generator and by the ship/grid drawing blocks.
package vga_pkg;

    localparam int CONT_W = 10;

    localparam int H_ATIVO  = 640;
    localparam int H_FRENTE = 16;
    localparam int H_PULSO  = 96;
    localparam int H_TRAS   = 48;

    localparam int V_ATIVO  = 480;
    localparam int V_FRENTE = 10;
    localparam int V_PULSO  = 2;
    localparam int V_TRAS   = 33;

    localparam int DIV_PIXEL = 2;
    localparam int POL_SYNC  = 0;

    localparam int H_TOTAL = H_ATIVO + H_FRENTE + H_PULSO + H_TRAS;
    localparam int V_TOTAL = V_ATIVO + V_FRENTE + V_PULSO + V_TRAS;

    localparam int H_SYNC_INI = H_ATIVO + H_FRENTE;
    localparam int H_SYNC_FIM = H_SYNC_INI + H_PULSO;
    localparam int V_SYNC_INI = V_ATIVO + V_FRENTE;
    localparam int V_SYNC_FIM = V_SYNC_INI + V_PULSO;

    // Grid mapping shared with the ship drawing blocks.
    localparam int CEL_LARGURA  = 54;
    localparam int CEL_ALTURA   = 49;
    localparam int GRADE_ORIGEM = 16;

    typedef logic [CONT_W-1:0] cont_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic area;
        logic inicio;
    } sinc_t;

    function automatic cont_t para_cont(input int v);
        return cont_t'(v);
    endfunction

endpackage

// File: rtl/vga_divisor_pixel.sv
// Pixel-enable divider: div counts 0..DIV_PIXEL-1, pixel_en on the last count.
// Ports: clk, rst_n (async, active-low), pixel_en (combinational from div).
module vga_divisor_pixel #(
    parameter int DIV_PIXEL = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixel_en
);

    localparam int DW = (DIV_PIXEL > 1) ? $clog2(DIV_PIXEL) : 1;
    localparam logic [DW-1:0] ULT = DW'(DIV_PIXEL - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (div == ULT) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Gated by rst_n so a 1-clock divider stays quiet during reset.
    assign pixel_en = rst_n & (div == ULT);

endmodule

// File: rtl/vga_sincronismo.sv
// VGA timing generator: hsync/vsync, linha/coluna, areaAtiva, inicioQuadro.
// Ports: clk, rst_n in; hsync, vsync, areaAtiva, linha, coluna, pixelEn, inicioQuadro out.
module vga_sincronismo #(
    parameter int H_ATIVO   = vga_pkg::H_ATIVO,
    parameter int H_FRENTE  = vga_pkg::H_FRENTE,
    parameter int H_PULSO   = vga_pkg::H_PULSO,
    parameter int H_TRAS    = vga_pkg::H_TRAS,
    parameter int V_ATIVO   = vga_pkg::V_ATIVO,
    parameter int V_FRENTE  = vga_pkg::V_FRENTE,
    parameter int V_PULSO   = vga_pkg::V_PULSO,
    parameter int V_TRAS    = vga_pkg::V_TRAS,
    parameter int DIV_PIXEL = vga_pkg::DIV_PIXEL,
    parameter int POL_SYNC  = vga_pkg::POL_SYNC
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       areaAtiva,
    output logic [9:0] linha,
    output logic [9:0] coluna,
    output logic       pixelEn,
    output logic       inicioQuadro
);

    import vga_pkg::*;

    localparam int TOT_H = H_ATIVO + H_FRENTE + H_PULSO + H_TRAS;
    localparam int TOT_V = V_ATIVO + V_FRENTE + V_PULSO + V_TRAS;

    if (TOT_H - 1 > 1023 || TOT_V - 1 > 1023) begin : g_erro_largura
        $error("vga_sincronismo: totals do not fit 10-bit counters");
    end
    if (DIV_PIXEL < 1) begin : g_erro_div
        $error("vga_sincronismo: DIV_PIXEL must be >= 1");
    end

    localparam cont_t COL_ULT = cont_t'(TOT_H - 1);
    localparam cont_t LIN_ULT = cont_t'(TOT_V - 1);
    localparam cont_t COL_VIS = cont_t'(H_ATIVO);
    localparam cont_t LIN_VIS = cont_t'(V_ATIVO);
    localparam cont_t HS_INI  = cont_t'(H_ATIVO + H_FRENTE);
    localparam cont_t HS_FIM  = cont_t'(H_ATIVO + H_FRENTE + H_PULSO);
    localparam cont_t VS_INI  = cont_t'(V_ATIVO + V_FRENTE);
    localparam cont_t VS_FIM  = cont_t'(V_ATIVO + V_FRENTE + V_PULSO);
    localparam logic  POL     = (POL_SYNC != 0);

    localparam sinc_t SINC_RST = '{
        hsync:  ~POL,
        vsync:  ~POL,
        area:   1'b0,
        inicio: 1'b0
    };

    function automatic sinc_t decodifica(input cont_t c, input cont_t l);
        sinc_t s;
        s.hsync  = (c >= HS_INI && c < HS_FIM) ? POL : ~POL;
        s.vsync  = (l >= VS_INI && l < VS_FIM) ? POL : ~POL;
        s.area   = (c < COL_VIS) && (l < LIN_VIS);
        s.inicio = (c == '0) && (l == '0);
        return s;
    endfunction

    logic  pixel_en;
    cont_t col;
    cont_t lin;
    cont_t col_prox;
    cont_t lin_prox;
    sinc_t sinc;
    sinc_t sinc_prox;

    vga_divisor_pixel #(
        .DIV_PIXEL(DIV_PIXEL)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .pixel_en(pixel_en)
    );

    always_comb begin
        col_prox = col + 1'b1;
        lin_prox = lin;
        if (col == COL_ULT) begin
            col_prox = '0;
            lin_prox = (lin == LIN_ULT) ? '0 : lin + 1'b1;
        end
    end

    // Decodes come from the next counter values so they stay aligned.
    assign sinc_prox = decodifica(col_prox, lin_prox);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            lin  <= '0;
            sinc <= SINC_RST;
        end else if (pixel_en) begin
            col  <= col_prox;
            lin  <= lin_prox;
            sinc <= sinc_prox;
        end
    end

    assign coluna       = col;
    assign linha        = lin;
    assign hsync        = sinc.hsync;
    assign vsync        = sinc.vsync;
    assign areaAtiva    = sinc.area;
    assign inicioQuadro = sinc.inicio;
    assign pixelEn      = pixel_en;

endmodule

// File: tb/tb_vga_sincronismo.sv
// Directed bench for vga_sincronismo: default timing, a small DIV=2 frame
// and a small DIV=1 / positive-sync frame.
module tb_vga_sincronismo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;

    logic       hs_a, vs_a, ar_a, pe_a, iq_a;
    logic [9:0] li_a, co_a;
    logic       hs_b, vs_b, ar_b, pe_b, iq_b;
    logic [9:0] li_b, co_b;
    logic       hs_c, vs_c, ar_c, pe_c, iq_c;
    logic [9:0] li_c, co_c;

    int total = 0;
    int bad = 0;

    vga_sincronismo dut_a (
        .clk(clk), .rst_n(rst_a), .hsync(hs_a), .vsync(vs_a),
        .areaAtiva(ar_a), .linha(li_a), .coluna(co_a),
        .pixelEn(pe_a), .inicioQuadro(iq_a)
    );

    // 15 x 8 frame: hsync 10..12, vsync 5..6, visible 8 x 4.
    vga_sincronismo #(
        .H_ATIVO(8), .H_FRENTE(2), .H_PULSO(3), .H_TRAS(2),
        .V_ATIVO(4), .V_FRENTE(1), .V_PULSO(2), .V_TRAS(1),
        .DIV_PIXEL(2), .POL_SYNC(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .hsync(hs_b), .vsync(vs_b),
        .areaAtiva(ar_b), .linha(li_b), .coluna(co_b),
        .pixelEn(pe_b), .inicioQuadro(iq_b)
    );

    vga_sincronismo #(
        .H_ATIVO(8), .H_FRENTE(2), .H_PULSO(3), .H_TRAS(2),
        .V_ATIVO(4), .V_FRENTE(1), .V_PULSO(2), .V_TRAS(1),
        .DIV_PIXEL(1), .POL_SYNC(1)
    ) dut_c (
        .clk(clk), .rst_n(rst_c), .hsync(hs_c), .vsync(vs_c),
        .areaAtiva(ar_c), .linha(li_c), .coluna(co_c),
        .pixelEn(pe_c), .inicioQuadro(iq_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until a DUT sits on the given column/line.
    task automatic go(input int sel, input int c, input int l);
        logic hit;
        logic [9:0] cc, ll;
        hit = 1'b0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: begin cc = co_a; ll = li_a; end
                1: begin cc = co_b; ll = li_b; end
                default: begin cc = co_c; ll = li_c; end
            endcase
            hit = (cc == 10'(c)) && (ll == 10'(l));
        end
        chk($sformatf("reach_%0d_%0d_%0d", sel, c, l), 32'(hit), 1);
    endtask

    initial begin
        int n, nh, nv, na, ni, np;
        logic prev;

        step(3);
        chk("a_rst_col", 32'(co_a), 0);
        chk("a_rst_lin", 32'(li_a), 0);
        chk("a_rst_hs", 32'(hs_a), 1);
        chk("a_rst_vs", 32'(vs_a), 1);
        chk("a_rst_area", 32'(ar_a), 0);
        chk("a_rst_iq", 32'(iq_a), 0);
        chk("a_rst_pe", 32'(pe_a), 0);
        chk("c_rst_pe", 32'(pe_c), 0);
        chk("c_rst_hs", 32'(hs_c), 0);
        chk("c_rst_vs", 32'(vs_c), 0);

        rst_a = 1'b1;
        #1;
        chk("a_rel_pe0", 32'(pe_a), 0);
        step(1);
        chk("a_p1_pe", 32'(pe_a), 1);
        chk("a_p1_col", 32'(co_a), 0);
        chk("a_p1_area", 32'(ar_a), 0);
        step(1);
        chk("a_p2_col", 32'(co_a), 1);
        chk("a_p2_lin", 32'(li_a), 0);
        chk("a_p2_area", 32'(ar_a), 1);
        chk("a_p2_hs", 32'(hs_a), 1);
        chk("a_p2_vs", 32'(vs_a), 1);
        chk("a_p2_pe", 32'(pe_a), 0);
        chk("a_p2_iq", 32'(iq_a), 0);

        go(0, 639, 0);
        chk("a_639_area", 32'(ar_a), 1);
        step(2);
        chk("a_640_col", 32'(co_a), 640);
        chk("a_640_area", 32'(ar_a), 0);
        go(0, 655, 0);
        chk("a_655_hs", 32'(hs_a), 1);
        step(2);
        chk("a_656_hs", 32'(hs_a), 0);
        n = 0;
        while (hs_a == 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("a_hs_clks", 32'(n), 192);
        chk("a_hs_end_col", 32'(co_a), 752);
        go(0, 799, 0);
        step(2);
        chk("a_wrap_col", 32'(co_a), 0);
        chk("a_wrap_lin", 32'(li_a), 1);
        chk("a_wrap_area", 32'(ar_a), 1);
        chk("a_wrap_iq", 32'(iq_a), 0);

        go(0, 700, 1);
        chk("a_mid_hs", 32'(hs_a), 0);
        #2 rst_a = 1'b0;
        #1;
        chk("a_arst_col", 32'(co_a), 0);
        chk("a_arst_lin", 32'(li_a), 0);
        chk("a_arst_hs", 32'(hs_a), 1);
        chk("a_arst_area", 32'(ar_a), 0);
        chk("a_arst_pe", 32'(pe_a), 0);
        step(1);
        rst_a = 1'b1;
        step(2);
        chk("a_restart_col", 32'(co_a), 1);
        chk("a_restart_lin", 32'(li_a), 0);
        chk("a_restart_hs", 32'(hs_a), 1);

        rst_b = 1'b1;
        go(1, 14, 7);
        step(2);
        chk("b_wrap_col", 32'(co_b), 0);
        chk("b_wrap_lin", 32'(li_b), 0);
        chk("b_wrap_iq", 32'(iq_b), 1);
        chk("b_wrap_area", 32'(ar_b), 1);
        n = 0; nh = 0; nv = 0; na = 0; ni = 0;
        prev = 1'b1;
        do begin
            prev = iq_b;
            @(negedge clk);
            n++;
            nh += (hs_b == 1'b0) ? 1 : 0;
            nv += (vs_b == 1'b0) ? 1 : 0;
            na += (ar_b == 1'b1) ? 1 : 0;
            ni += (iq_b == 1'b1) ? 1 : 0;
        end while (!(iq_b && !prev) && n < 2000);
        chk("b_frame_clks", 32'(n), 240);
        chk("b_hs_low", 32'(nh), 48);
        chk("b_vs_low", 32'(nv), 60);
        chk("b_area", 32'(na), 64);
        chk("b_iq_clks", 32'(ni), 2);

        @(negedge clk);
        rst_c = 1'b1;
        #1;
        chk("c_rel_pe", 32'(pe_c), 1);
        np = 0; nh = 0; nv = 0; na = 0; ni = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            np += (pe_c == 1'b1) ? 1 : 0;
            nh += (hs_c == 1'b1) ? 1 : 0;
            nv += (vs_c == 1'b1) ? 1 : 0;
            na += (ar_c == 1'b1) ? 1 : 0;
            ni += (iq_c == 1'b1) ? 1 : 0;
        end
        chk("c_pe", 32'(np), 120);
        chk("c_hs_high", 32'(nh), 24);
        chk("c_vs_high", 32'(nv), 30);
        chk("c_area", 32'(na), 32);
        chk("c_iq", 32'(ni), 1);
        go(2, 9, 0);
        chk("c_9_hs", 32'(hs_c), 0);
        step(1);
        chk("c_10_col", 32'(co_c), 10);
        chk("c_10_hs", 32'(hs_c), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
